// File: rtl/dmem_responder_if.sv
// Load/store request interface between a requester (core memory stage) and
// the data-memory responder.
//   master : drives req_i, we_i, addr_i, wdata_i, be_i; observes responses
//   slave  : drives ready_o, rvalid_o, rdata_o, err_o, busy_o
interface dmem_responder_if;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned BW = DW / 8;

   logic          req_i;
   logic          we_i;
   logic [AW-1:0] addr_i;
   logic [DW-1:0] wdata_i;
   logic [BW-1:0] be_i;
   logic          ready_o;
   logic          rvalid_o;
   logic [DW-1:0] rdata_o;
   logic          err_o;
   logic          busy_o;

   modport master (
      output req_i, we_i, addr_i, wdata_i, be_i,
      input  ready_o, rvalid_o, rdata_o, err_o, busy_o
   );

   modport slave (
      input  req_i, we_i, addr_i, wdata_i, be_i,
      output ready_o, rvalid_o, rdata_o, err_o, busy_o
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory responding to load/store requests with a fixed
// number of wait states and a single-cycle response pulse.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : request (req/we/addr/wdata/be) in, response (ready/rvalid/rdata/
//          err/busy) out
// Parameters: DEPTH = number of 32-bit words, WAIT = wait states (0..15).
module dmem_responder #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WAIT  = 2
) (
   input  logic             clk,
   input  logic             rst,
   dmem_responder_if.slave  bus
);
   localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_n;
   logic [CW-1:0]   cnt_q, cnt_n;
   logic            we_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic            accept_c;
   logic            access_c;
   logic            err_c;
   logic [IW-1:0]   idx_c;

   logic [31:0]     mem [DEPTH];

   // Address decode of the latched request
   always_comb begin
      err_c = (addr_q[1:0] != 2'b00) || (addr_q[31:2] >= 30'(DEPTH));
      idx_c = addr_q[IW+1:2];
   end

   // Next-state, wait counter, accept/access strobes
   always_comb begin
      state_n  = state_q;
      cnt_n    = cnt_q;
      accept_c = 1'b0;
      access_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.req_i) begin
               accept_c = 1'b1;
               cnt_n    = CW'(WAIT);
               state_n  = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q != '0) begin
               cnt_n = cnt_q - CW'(1);
            end else begin
               access_c = 1'b1;
               state_n  = S_RESP;
            end
         end
         S_RESP: begin
            // Back-to-back: a request seen during the response is accepted
            if (bus.req_i) begin
               accept_c = 1'b1;
               cnt_n    = CW'(WAIT);
               state_n  = S_WAIT;
            end else begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // State, request latch and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         be_q         <= '0;
         bus.ready_o  <= 1'b1;
         bus.rvalid_o <= 1'b0;
         bus.busy_o   <= 1'b0;
         bus.rdata_o  <= '0;
         bus.err_o    <= 1'b0;
      end else begin
         state_q      <= state_n;
         cnt_q        <= cnt_n;
         bus.ready_o  <= (state_n != S_WAIT);
         bus.rvalid_o <= (state_n == S_RESP);
         bus.busy_o   <= (state_n == S_WAIT);
         if (accept_c) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
            be_q    <= bus.be_i;
         end
         if (access_c) begin
            bus.err_o   <= err_c;
            bus.rdata_o <= (err_c || we_q) ? 32'h0 : mem[idx_c];
         end
      end
   end

   // Byte-masked store; array is deliberately not reset
   always_ff @(posedge clk) begin
      if (access_c && we_q && !err_c) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT=2 instance for functional,
// error, back-to-back and reset cases, plus a WAIT=0 instance for latency
// and streaming throughput.
module tb_dmem_responder;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   dmem_responder_if bus  ();
   dmem_responder_if bus0 ();

   dmem_responder #(.DEPTH(256), .WAIT(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   dmem_responder #(.DEPTH(256), .WAIT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (bus0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // One transaction on the WAIT=2 instance; entered #1 after an edge with
   // the responder idle, leaves it idle again.
   task automatic do_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         input logic [31:0] exp_rdata, input logic exp_err);
      int   g;
      int   lat;
      logic rdy_bad;
      bus.req_i   = 1'b1;
      bus.we_i    = we;
      bus.addr_i  = addr;
      bus.wdata_i = wdata;
      bus.be_i    = be;
      g = 0;
      while (!bus.ready_o && g < 32) begin
         @(posedge clk); #1; g++;
      end
      @(posedge clk); #1;
      // Scramble inputs after accept: the responder must use its latched copy
      bus.req_i   = 1'b0;
      bus.we_i    = ~we;
      bus.addr_i  = 32'hFFFF_FFFC;
      bus.wdata_i = 32'h5A5A_5A5A;
      bus.be_i    = 4'hF;
      lat     = 0;
      rdy_bad = 1'b0;
      while (!bus.rvalid_o && lat < 32) begin
         if (bus.ready_o) rdy_bad = 1'b1;
         @(posedge clk); #1; lat++;
      end
      check({tag, ".lat"}, 32'(lat), 32'd3);
      check({tag, ".ready_low"}, 32'(rdy_bad), 32'd0);
      check({tag, ".rdata"}, bus.rdata_o, exp_rdata);
      check({tag, ".err"}, 32'(bus.err_o), 32'(exp_err));
      @(posedge clk); #1;
   endtask

   initial begin
      int          t1;
      int          t2;
      int          first;
      int          nresp;
      logic        rdy_bad;
      logic        e1;
      logic        seen;
      logic        gap_bad;
      logic        data_bad;
      logic        exp_v;
      logic [31:0] r2;

      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      bus.req_i  = 1'b0; bus.we_i  = 1'b0; bus.addr_i  = '0; bus.wdata_i  = '0; bus.be_i  = '0;
      bus0.req_i = 1'b0; bus0.we_i = 1'b0; bus0.addr_i = '0; bus0.wdata_i = '0; bus0.be_i = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst.ready",  32'(bus.ready_o),  32'd1);
      check("rst.rvalid", 32'(bus.rvalid_o), 32'd0);
      check("rst.rdata",  bus.rdata_o,       32'h0);
      check("rst.err",    32'(bus.err_o),    32'd0);
      check("rst.busy",   32'(bus.busy_o),   32'd0);
      check("rst0.ready", 32'(bus0.ready_o), 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // Full word, partial and empty byte enables, loads ignore be
      do_txn("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
      do_txn("ld_full", 1'b0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 1'b0);
      do_txn("st_part", 1'b1, 32'h10, 32'h0000AA00, 4'h2, 32'h0,        1'b0);
      do_txn("ld_part", 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADAAEF, 1'b0);
      do_txn("st_none", 1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
      do_txn("ld_none", 1'b0, 32'h10, 32'h0,        4'hF, 32'hDEADAAEF, 1'b0);

      // Errors: misaligned load, out-of-range store must not alias word 0
      do_txn("st_w0",   1'b1, 32'h0,   32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
      do_txn("ld_mis",  1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1);
      do_txn("st_oor",  1'b1, 32'h400, 32'h11111111, 4'hF, 32'h0,        1'b1);
      do_txn("ld_w0",   1'b0, 32'h0,   32'h0,        4'hF, 32'hCAFEF00D, 1'b0);
      do_txn("ld_w10",  1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADAAEF, 1'b0);

      // Back-to-back: store 0x20 then load 0x20 with req held throughout
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20;
      bus.wdata_i = 32'h12345678; bus.be_i = 4'hF;
      t1 = -1; t2 = -1; rdy_bad = 1'b0; e1 = 1'b1; r2 = '0;
      for (int i = 0; i < 16; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            bus.we_i = 1'b0; bus.wdata_i = 32'h0;
         end
         if (t1 >= 0 && i == t1 + 1) bus.req_i = 1'b0;
         if ((i inside {0, 1, 2, 4, 5, 6}) && bus.ready_o) rdy_bad = 1'b1;
         if (bus.rvalid_o) begin
            if (t1 < 0) begin
               t1 = i; e1 = bus.err_o;
            end else if (t2 < 0) begin
               t2 = i; r2 = bus.rdata_o;
            end
         end
      end
      bus.req_i = 1'b0;
      check("b2b.first_resp", 32'(t1),      32'd3);
      check("b2b.gap",        32'(t2 - t1), 32'd4);
      check("b2b.st_err",     32'(e1),      32'd0);
      check("b2b.ld_rdata",   r2,           32'h12345678);
      check("b2b.ready_low",  32'(rdy_bad), 32'd0);

      // Reset while a store sits in WAIT: store is dropped, outputs cleared
      do_txn("st_pre30", 1'b1, 32'h30, 32'h0, 4'hF, 32'h0,        1'b0);
      do_txn("ld_keep",  1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0);
      bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h30;
      bus.wdata_i = 32'hFFFFFFFF; bus.be_i = 4'hF;
      @(posedge clk); #1;
      bus.req_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rmid.ready",  32'(bus.ready_o),  32'd1);
      check("rmid.rvalid", 32'(bus.rvalid_o), 32'd0);
      check("rmid.busy",   32'(bus.busy_o),   32'd0);
      check("rmid.rdata",  bus.rdata_o,       32'h0);
      check("rmid.err",    32'(bus.err_o),    32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         if (bus.rvalid_o) seen = 1'b1;
      end
      check("rmid.no_rvalid", 32'(seen), 32'd0);
      do_txn("ld_30", 1'b0, 32'h30, 32'h0, 4'hF, 32'h0, 1'b0);

      // WAIT=0: store then a held stream of loads, one response per 2 cycles
      bus0.req_i = 1'b1; bus0.we_i = 1'b1; bus0.addr_i = 32'h40;
      bus0.wdata_i = 32'hA5A5A5A5; bus0.be_i = 4'hF;
      first = -1; nresp = 0; gap_bad = 1'b0; data_bad = 1'b0;
      for (int i = 0; i < 11; i++) begin
         @(posedge clk); #1;
         if (i == 0) begin
            bus0.we_i = 1'b0; bus0.wdata_i = 32'h0;
         end
         exp_v = (i % 2 == 1) && (i <= 9);
         if (bus0.rvalid_o !== exp_v) gap_bad = 1'b1;
         if (bus0.rvalid_o) begin
            nresp++;
            if (first < 0) first = i;
            if (i > 1 && bus0.rdata_o !== 32'hA5A5A5A5) data_bad = 1'b1;
            if (bus0.err_o) data_bad = 1'b1;
         end
         if (i == 9) bus0.req_i = 1'b0;
      end
      check("w0.first_lat", 32'(first),    32'd1);
      check("w0.nresp",     32'(nresp),    32'd5);
      check("w0.spacing",   32'(gap_bad),  32'd0);
      check("w0.data",      32'(data_bad), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
